m_control_fsm: RTL and testbench
================================

Name: m_control_fsm

Overview:
- Sequencing controller for the M-extension mul/div unit.
- Accepts one RV32M operation (funct3) and drives the mux selects of the remainder/divisor/quotient/multiplier-operand datapath registers.
- Multiply: load → issue operands → wait → capture. Divide/remainder: 32-iteration restoring shift-subtract.
- Reports busy/done plus result-select and result-negate flags to the writeback logic.

Parameters:
- MUL_LATENCY, 1: cycles from registered multiplier operands to registered product valid, ≥1.
- DIV_ITERS, 32: shift-subtract iterations (equals XLEN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request; accepted only in IDLE
- funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_sign  in  1  rs1[31], valid with start
- rs2_sign  in  1  rs2[31], valid with start
- rs2_zero  in  1  rs2==0, valid with start
- sub_neg  in  1  datapath subtractor result negative
- kill  in  1  abort the current operation
- mux_R  out  3  remainder select
- mux_D  out  2  divisor select
- mux_Z  out  2  quotient select
- mux_multA  out  2  multiplier A select
- mux_multB  out  2  multiplier B select
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; datapath result valid this cycle
- result_sel  out  1  0 = take R, 1 = take Z
- result_neg  out  1  writeback must two's-complement the selected result

Behaviour:
- Reset and kill:
  - reset → state IDLE, counter 0, latched op/flags 0.
  - Reset forces IDLE from any state, including mid-division; no done is produced.
  - kill (not during reset) → IDLE next cycle, no done. kill outranks start in the same cycle.
- IDLE outputs:
  - mux_R/D/Z = KEEP; mux_multA/B = ZERO.
  - busy = done = result_sel = result_neg = 0.
- Start cycle (Mealy):
  - In IDLE with start=1 and kill=0: latch funct3, rs1_sign, rs2_sign, rs2_zero.
  - Same cycle, drive load selects from the unlatched inputs:
    - Mul, DIVU, REMU: mux_R = A, mux_D = B.
    - DIV/REM: mux_R = A_NEG if rs1_sign else A; mux_D = B_NEG if rs2_sign else B.
    - Div ops also drive mux_Z = ZERO.
  - start while busy is ignored; no queuing.
- Multiply path: MUL_OPS (1 cycle) → MUL_WAIT (MUL_LATENCY cycles, counted) → MUL_CAP (1 cycle) → DONE.
  - Operand selects, held constant from MUL_OPS through MUL_CAP:
    - MUL, MULHU: R_UNSIGNED / D_UNSIGNED.
    - MULH: R_SIGNED / D_SIGNED.
    - MULHSU: R_SIGNED / D_UNSIGNED.
  - MUL_CAP: mux_R = MULT_LOWER, mux_Z = MULT_UPPER. Upper-half extraction depends on the held selects.
  - done asserts 3+MUL_LATENCY cycles after the start cycle (4 with default).
  - result_sel = 0 for MUL, 1 otherwise; result_neg = 0.
- Divide path: DIV_ITER for DIV_ITERS cycles, then DONE.
  - Each DIV_ITER cycle: mux_R = SUB_KEEP, mux_Z = SHL_ADD, mux_D = SHR; mux_multA/B = ZERO.
  - Counter runs 0..DIV_ITERS-1; the last iteration moves to DONE.
  - done asserts DIV_ITERS+1 cycles after the start cycle (33).
  - result_sel = 1 for DIV/DIVU, 0 for REM/REMU.
  - result_neg:
    - DIV: (rs1_sign ^ rs2_sign) & ~rs2_zero.
    - REM: rs1_sign.
    - unsigned ops: 0.
  - Divide by zero needs no special path: quotient is all-ones with no negation; remainder = dividend.
  - Overflow (−2^31 / −1) yields 0x80000000, remainder 0, naturally.
- DONE (1 cycle):
  - All muxes KEEP, multA/B ZERO, busy = 0, done = 1; result_sel/result_neg valid.
  - Returns to IDLE. A start in DONE is ignored.
- busy = 1 in every state except IDLE and DONE.
- sub_neg is consumed inside the datapath. The FSM only observes it (assertion: never X during DIV_ITER).

Decomposition:
- Shared package/definitions header holds:
  - mux encodings MUX_R_* (KEEP, A, A_NEG, SUB_KEEP, MULT_LOWER), MUX_D_* (KEEP, B, B_NEG, SHR), MUX_Z_* (KEEP, ZERO, SHL_ADD, MULT_UPPER), MUX_MULTA_*/MUX_MULTB_* (UNSIGNED, SIGNED, ZERO);
  - the *_LENGTH widths;
  - the funct3 opcode constants;
  - the state enum typedef.
- No sub-module; a single FSM plus one counter.

Test Plan:
- MULH, rs1=0xFFFFFFFF, rs2=0x00000002 (rs1_sign=1): multA = R_SIGNED, multB = D_SIGNED for 3 cycles; MUL_CAP drives MULT_LOWER/MULT_UPPER; done at start+4; result_sel=1; with datapath, Z=0xFFFFFFFF.
- DIV, rs1=−7, rs2=2: start cycle mux_R=A_NEG, mux_D=B, mux_Z=ZERO; 32 SUB_KEEP/SHL_ADD/SHR cycles; done at start+33; result_sel=1, result_neg=1; quotient −3.
- REM, rs1=−7, rs2=2: result_sel=0, result_neg=1; remainder −1.
- DIVU by zero, rs1=0x12345678: result_neg=0; Z=0xFFFFFFFF. REMU same operands gives R=0x12345678.
- start pulsed during DIV_ITER cycle 10: ignored; exactly one done at start+33. Start in the DONE cycle is also ignored.
- reset at DIV_ITER cycle 5 (and kill at MUL_WAIT in a second run): IDLE next cycle, all selects KEEP/ZERO, no done; the next start runs normally.

Source files
------------

// File: rtl/m_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// m_control_fsm_pkg
// Shared definitions for the M-extension mul/div sequencing controller:
//   - datapath mux select encodings (remainder R, divisor D, quotient Z,
//     multiplier operands A/B) and their widths
//   - RV32M funct3 opcodes
//   - controller state enum
//   - small funct3 classification helpers
// -----------------------------------------------------------------------------
package m_control_fsm_pkg;

    localparam int MUX_R_LENGTH    = 3;
    localparam int MUX_D_LENGTH    = 2;
    localparam int MUX_Z_LENGTH    = 2;
    localparam int MUX_MULT_LENGTH = 2;
    localparam int FUNCT3_LENGTH   = 3;

    // Remainder register select
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd3;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd4;

    // Divisor register select
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

    // Quotient register select
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd2;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd3;

    // Multiplier operand selects (A reads R, B reads D)
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTA_UNSIGNED = 2'd0;
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTA_SIGNED   = 2'd1;
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTA_ZERO     = 2'd2;
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTB_UNSIGNED = 2'd0;
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTB_SIGNED   = 2'd1;
    localparam logic [MUX_MULT_LENGTH-1:0] MUX_MULTB_ZERO     = 2'd2;

    // RV32M funct3
    localparam logic [FUNCT3_LENGTH-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULHU  = 3'b011;
    localparam logic [FUNCT3_LENGTH-1:0] F3_DIV    = 3'b100;
    localparam logic [FUNCT3_LENGTH-1:0] F3_DIVU   = 3'b101;
    localparam logic [FUNCT3_LENGTH-1:0] F3_REM    = 3'b110;
    localparam logic [FUNCT3_LENGTH-1:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_OPS,
        ST_MUL_WAIT,
        ST_MUL_CAP,
        ST_DIV_ITER,
        ST_DONE
    } state_t;

    // Any divide or remainder op.
    function automatic logic f3_is_div(input logic [FUNCT3_LENGTH-1:0] f3);
        return f3[2];
    endfunction

    // Signed divide/remainder: operands are made positive before iterating.
    function automatic logic f3_is_signed_div(input logic [FUNCT3_LENGTH-1:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/m_control_fsm_if.sv
// -----------------------------------------------------------------------------
// m_control_fsm_if
// Bundle between the issue/datapath side (master) and the mul/div sequencing
// controller (slave).
//   Requests  : start, funct3, rs1_sign, rs2_sign, rs2_zero, kill
//   Feedback  : sub_neg (datapath subtractor sign)
//   Selects   : mux_R, mux_D, mux_Z, mux_multA, mux_multB
//   Status    : busy, done, result_sel, result_neg
// -----------------------------------------------------------------------------
interface m_control_fsm_if;
    import m_control_fsm_pkg::*;

    logic                       start;
    logic [FUNCT3_LENGTH-1:0]   funct3;
    logic                       rs1_sign;
    logic                       rs2_sign;
    logic                       rs2_zero;
    logic                       sub_neg;
    logic                       kill;

    logic [MUX_R_LENGTH-1:0]    mux_R;
    logic [MUX_D_LENGTH-1:0]    mux_D;
    logic [MUX_Z_LENGTH-1:0]    mux_Z;
    logic [MUX_MULT_LENGTH-1:0] mux_multA;
    logic [MUX_MULT_LENGTH-1:0] mux_multB;
    logic                       busy;
    logic                       done;
    logic                       result_sel;
    logic                       result_neg;

    modport master (
        output start, funct3, rs1_sign, rs2_sign, rs2_zero, sub_neg, kill,
        input  mux_R, mux_D, mux_Z, mux_multA, mux_multB,
        input  busy, done, result_sel, result_neg
    );

    modport slave (
        input  start, funct3, rs1_sign, rs2_sign, rs2_zero, sub_neg, kill,
        output mux_R, mux_D, mux_Z, mux_multA, mux_multB,
        output busy, done, result_sel, result_neg
    );

endinterface

// File: rtl/m_control_fsm.sv
// -----------------------------------------------------------------------------
// m_control_fsm
// Sequencing controller for the RV32M mul/div datapath.
//   Multiply : IDLE(load) -> MUL_OPS -> MUL_WAIT x MUL_LATENCY -> MUL_CAP -> DONE
//   Divide   : IDLE(load) -> DIV_ITER x DIV_ITERS -> DONE (restoring shift-subtract)
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset
//   bus    - m_control_fsm_if.slave: request/abort in, mux selects and
//            busy/done/result_sel/result_neg out
// -----------------------------------------------------------------------------
module m_control_fsm
    import m_control_fsm_pkg::*;
#(
    parameter int MUL_LATENCY = 1,   // >= 1
    parameter int DIV_ITERS   = 32   // equals XLEN
) (
    input  logic           clk,
    input  logic           reset,
    m_control_fsm_if.slave bus
);

    localparam int CNT_MAX = (MUL_LATENCY > DIV_ITERS) ? MUL_LATENCY : DIV_ITERS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_next;
    logic                       w_accept;

    logic [FUNCT3_LENGTH-1:0]   r_funct3;
    logic                       r_rs1_sign;
    logic                       r_rs2_sign;
    logic                       r_rs2_zero;

    logic [MUX_MULT_LENGTH-1:0] w_op_a_sel;
    logic [MUX_MULT_LENGTH-1:0] w_op_b_sel;
    logic                       w_res_sel;
    logic                       w_res_neg;

    // Decode of the latched op: multiplier operand signedness and writeback flags.
    always_comb begin
        w_op_a_sel = MUX_MULTA_UNSIGNED;
        w_op_b_sel = MUX_MULTB_UNSIGNED;
        w_res_sel  = 1'b0;
        w_res_neg  = 1'b0;
        case (r_funct3)
            F3_MULH: begin
                w_op_a_sel = MUX_MULTA_SIGNED;
                w_op_b_sel = MUX_MULTB_SIGNED;
                w_res_sel  = 1'b1;
            end
            F3_MULHSU: begin
                w_op_a_sel = MUX_MULTA_SIGNED;
                w_res_sel  = 1'b1;
            end
            F3_MULHU: w_res_sel = 1'b1;
            F3_DIV: begin
                w_res_sel = 1'b1;
                // Divide by zero returns all-ones un-negated.
                w_res_neg = (r_rs1_sign ^ r_rs2_sign) & ~r_rs2_zero;
            end
            F3_DIVU: w_res_sel = 1'b1;
            F3_REM:  w_res_neg = r_rs1_sign;
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_accept       = 1'b0;
        bus.mux_R      = MUX_R_KEEP;
        bus.mux_D      = MUX_D_KEEP;
        bus.mux_Z      = MUX_Z_KEEP;
        bus.mux_multA  = MUX_MULTA_ZERO;
        bus.mux_multB  = MUX_MULTB_ZERO;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.result_sel = 1'b0;
        bus.result_neg = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Mealy load: operand registers are loaded from the raw request
                // in the same cycle the op is accepted.
                if (bus.start && !bus.kill) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = f3_is_div(bus.funct3) ? ST_DIV_ITER : ST_MUL_OPS;
                    bus.mux_R    = (f3_is_signed_div(bus.funct3) && bus.rs1_sign)
                                   ? MUX_R_A_NEG : MUX_R_A;
                    bus.mux_D    = (f3_is_signed_div(bus.funct3) && bus.rs2_sign)
                                   ? MUX_D_B_NEG : MUX_D_B;
                    if (f3_is_div(bus.funct3)) begin
                        bus.mux_Z = MUX_Z_ZERO;
                    end
                end
            end
            ST_MUL_OPS: begin
                bus.busy      = 1'b1;
                bus.mux_multA = w_op_a_sel;
                bus.mux_multB = w_op_b_sel;
                w_cnt_next    = '0;
                w_state_next  = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                bus.busy      = 1'b1;
                bus.mux_multA = w_op_a_sel;
                bus.mux_multB = w_op_b_sel;
                if (r_cnt == MUL_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_MUL_CAP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_MUL_CAP: begin
                // Selects stay held here: the upper-half extraction depends on them.
                bus.busy      = 1'b1;
                bus.mux_multA = w_op_a_sel;
                bus.mux_multB = w_op_b_sel;
                bus.mux_R     = MUX_R_MULT_LOWER;
                bus.mux_Z     = MUX_Z_MULT_UPPER;
                w_state_next  = ST_DONE;
            end
            ST_DIV_ITER: begin
                bus.busy  = 1'b1;
                bus.mux_R = MUX_R_SUB_KEEP;
                bus.mux_Z = MUX_Z_SHL_ADD;
                bus.mux_D = MUX_D_SHR;
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                bus.done     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (r_state != ST_IDLE) begin
            bus.result_sel = w_res_sel;
            bus.result_neg = w_res_neg;
        end

        // Abort wins over everything, including a same-cycle start.
        if (bus.kill) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_rs1_sign <= 1'b0;
            r_rs2_sign <= 1'b0;
            r_rs2_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the update order inside this block is irrelevant.
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_funct3   <= bus.funct3;
                r_rs1_sign <= bus.rs1_sign;
                r_rs2_sign <= bus.rs2_sign;
                r_rs2_zero <= bus.rs2_zero;
            end
        end
    end

    // sub_neg steers R and Z on every iteration; an unknown value means the
    // datapath registers were never loaded.
    a_sub_neg_known: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_DIV_ITER) |-> !$isunknown(bus.sub_neg));

endmodule

// File: tb/tb_m_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_m_control_fsm
// Bench for m_control_fsm. A behavioural R/D/Z/multiplier datapath follows the
// controller's selects and closes the sub_neg loop; reference results computed
// from the operands are queued at start and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_m_control_fsm;
    import m_control_fsm_pkg::*;

    localparam int MUL_LATENCY = 1;
    localparam int DIV_ITERS   = 32;
    localparam int MUL_DONE    = 3 + MUL_LATENCY;
    localparam int DIV_DONE    = DIV_ITERS + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    m_control_fsm_if bus ();

    m_control_fsm #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_ITERS   (DIV_ITERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    typedef struct {
        logic [2:0]  funct3;
        logic [31:0] result;
        logic        sel;
        logic        neg;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- behavioural datapath ----------------
    // D holds the divisor pre-aligned at bit 31; the multiplier reads it back from there.
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [63:0] dp_r = '0;
    logic [63:0] dp_d = '0;
    logic [31:0] dp_z = '0;
    logic [63:0] dp_ma = '0;
    logic [63:0] dp_mb = '0;
    logic [63:0] dp_prod = '0;
    logic [31:0] wb_val;

    assign bus.sub_neg = (dp_r < dp_d);

    function automatic logic [63:0] mult_operand(input logic [1:0] sel, input logic [31:0] v);
        if (sel == MUX_MULTA_SIGNED)   return {{32{v[31]}}, v};
        if (sel == MUX_MULTA_UNSIGNED) return {32'b0, v};
        return 64'd0;
    endfunction

    always @(posedge clk) begin
        case (bus.mux_R)
            MUX_R_A:          dp_r <= {32'b0, op_a};
            MUX_R_A_NEG:      dp_r <= {32'b0, -op_a};
            MUX_R_SUB_KEEP:   if (!bus.sub_neg) dp_r <= dp_r - dp_d;
            MUX_R_MULT_LOWER: dp_r <= {32'b0, dp_prod[31:0]};
            default: ;
        endcase
        case (bus.mux_D)
            MUX_D_B:     dp_d <= {32'b0, op_b} << 31;
            MUX_D_B_NEG: dp_d <= {32'b0, -op_b} << 31;
            MUX_D_SHR:   dp_d <= dp_d >> 1;
            default: ;
        endcase
        case (bus.mux_Z)
            MUX_Z_ZERO:       dp_z <= '0;
            MUX_Z_SHL_ADD:    dp_z <= {dp_z[30:0], ~bus.sub_neg};
            MUX_Z_MULT_UPPER: dp_z <= dp_prod[63:32];
            default: ;
        endcase
        dp_ma   <= mult_operand(bus.mux_multA, dp_r[31:0]);
        dp_mb   <= mult_operand(bus.mux_multB, dp_d[62:31]);
        dp_prod <= dp_ma * dp_mb;
    end

    always_comb begin
        wb_val = bus.result_sel ? dp_z : dp_r[31:0];
        if (bus.result_neg) wb_val = -wb_val;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        qa = a;
        qb = b;
        p  = '0;
        ref_result = '0;
        case (f3)
            F3_MUL:    begin p = za * zb; ref_result = p[31:0];  end
            F3_MULH:   begin p = sa * sb; ref_result = p[63:32]; end
            F3_MULHSU: begin p = sa * zb; ref_result = p[63:32]; end
            F3_MULHU:  begin p = za * zb; ref_result = p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
                else ref_result = qa / qb;
            end
            F3_DIVU: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 32'd0) ref_result = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
                else ref_result = qa % qb;
            end
            default: ref_result = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            done_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done pulsed with no operation outstanding");
            end else begin
                e = sb_q.pop_front();
                if (wb_val !== e.result) begin
                    errors++;
                    $display("FAIL result f3=%0d: got %h expected %h", e.funct3, wb_val, e.result);
                end
                checks++;
                if (bus.result_sel !== e.sel) begin
                    errors++;
                    $display("FAIL result_sel f3=%0d: got %b expected %b", e.funct3, bus.result_sel, e.sel);
                end
                checks++;
                if (bus.result_neg !== e.neg) begin
                    errors++;
                    $display("FAIL result_neg f3=%0d: got %b expected %b", e.funct3, bus.result_neg, e.neg);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; returns at the falling edge of cycle 1.
    task automatic do_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input string name);
        exp_t       e;
        logic       sdiv;
        logic [2:0] er;
        logic [1:0] ed, ez;
        op_a          = a;
        op_b          = b;
        bus.funct3    = f3;
        bus.rs1_sign  = a[31];
        bus.rs2_sign  = b[31];
        bus.rs2_zero  = (b == 32'd0);
        bus.start     = 1'b1;
        e.funct3 = f3;
        e.result = ref_result(f3, a, b);
        e.sel    = !((f3 == F3_MUL) || (f3 == F3_REM) || (f3 == F3_REMU));
        e.neg    = (f3 == F3_DIV) ? ((a[31] ^ b[31]) & (b != 32'd0)) :
                   (f3 == F3_REM) ? a[31] : 1'b0;
        sb_q.push_back(e);
        sdiv = (f3 == F3_DIV) || (f3 == F3_REM);
        er   = (sdiv && a[31]) ? MUX_R_A_NEG : MUX_R_A;
        ed   = (sdiv && b[31]) ? MUX_D_B_NEG : MUX_D_B;
        ez   = f3[2] ? MUX_Z_ZERO : MUX_Z_KEEP;
        #1;
        checks++;
        if ({bus.mux_R, bus.mux_D, bus.mux_Z} !== {er, ed, ez}) begin
            errors++;
            $display("FAIL %s start_selects: got R=%0d D=%0d Z=%0d expected R=%0d D=%0d Z=%0d",
                     name, bus.mux_R, bus.mux_D, bus.mux_Z, er, ed, ez);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; cur is the cycle index of the current falling edge.
    task automatic wait_done(input int cur, input int exp_cycle, input string name);
        int n;
        n = cur;
        while (bus.done !== 1'b1 && n < cur + 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 || n != exp_cycle) begin
            errors++;
            $display("FAIL %s done_latency: got cycle %0d (done=%b) expected cycle %0d",
                     name, n, bus.done, exp_cycle);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        do_start(f3, a, b, name);
        wait_done(1, f3[2] ? DIV_DONE : MUL_DONE, name);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mux_R, bus.mux_D, bus.mux_Z, bus.mux_multA, bus.mux_multB, bus.busy, bus.done,
             bus.result_sel, bus.result_neg} !==
            {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO, MUX_MULTB_ZERO, 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: got R=%0d D=%0d Z=%0d A=%0d B=%0d busy=%b done=%b expected idle",
                     bus.mux_R, bus.mux_D, bus.mux_Z, bus.mux_multA, bus.mux_multB, bus.busy, bus.done);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mulh();
        int bad;
        bad = 0;
        do_start(F3_MULH, 32'hFFFF_FFFF, 32'h0000_0002, "mulh");
        for (int c = 1; c <= 3; c++) begin
            if (bus.mux_multA !== MUX_MULTA_SIGNED || bus.mux_multB !== MUX_MULTB_SIGNED ||
                bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            if (c == 3) begin
                checks++;
                if (bus.mux_R !== MUX_R_MULT_LOWER || bus.mux_Z !== MUX_Z_MULT_UPPER) begin
                    errors++;
                    $display("FAIL mulh_capture: got R=%0d Z=%0d expected R=%0d Z=%0d",
                             bus.mux_R, bus.mux_Z, MUX_R_MULT_LOWER, MUX_Z_MULT_UPPER);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mulh_operand_selects: got %0d bad cycles expected 0", bad);
        end
        wait_done(4, MUL_DONE, "mulh");
        @(negedge clk);
    endtask

    task automatic test_div();
        int bad;
        bad = 0;
        do_start(F3_DIV, 32'hFFFF_FFF9, 32'd2, "div");
        for (int c = 1; c <= DIV_ITERS; c++) begin
            if (bus.mux_R !== MUX_R_SUB_KEEP || bus.mux_Z !== MUX_Z_SHL_ADD || bus.mux_D !== MUX_D_SHR ||
                bus.mux_multA !== MUX_MULTA_ZERO || bus.mux_multB !== MUX_MULTB_ZERO ||
                bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_iter_selects: got %0d bad cycles expected 0", bad);
        end
        wait_done(DIV_DONE, DIV_DONE, "div");
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL div_done_busy: got %b expected 0", bus.busy);
        end
        @(negedge clk);
        run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, "rem");
    endtask

    task automatic test_div_by_zero();
        run_op(F3_DIVU, 32'h1234_5678, 32'd0, "divu_zero");
        run_op(F3_REMU, 32'h1234_5678, 32'd0, "remu_zero");
    endtask

    task automatic test_start_ignored();
        int dc;
        dc = done_count;
        do_start(F3_DIV, 32'd1000, 32'd7, "busy_start");
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;                    // cycle 10: mid-iteration
        bus.funct3 = F3_MUL;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(11, DIV_DONE, "busy_start");
        bus.start  = 1'b1;                    // in the DONE cycle
        bus.funct3 = F3_MULHU;
        #1;
        checks++;
        if (bus.mux_R !== MUX_R_KEEP || bus.mux_D !== MUX_D_KEEP) begin
            errors++;
            $display("FAIL done_start_selects: got R=%0d D=%0d expected KEEP", bus.mux_R, bus.mux_D);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: got busy=%b expected 0", bus.busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_count - dc != 1) begin
            errors++;
            $display("FAIL single_done: got %0d done pulses expected 1", done_count - dc);
        end
    endtask

    task automatic test_reset_mid_div();
        int   dc;
        exp_t e;
        dc = done_count;
        do_start(F3_DIV, 32'd12345, 32'd10, "reset_div");
        repeat (4) @(negedge clk);
        reset = 1'b1;                         // DIV_ITER cycle 5
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.mux_R, bus.mux_D, bus.mux_Z, bus.mux_multA, bus.mux_multB, bus.busy, bus.done} !==
            {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO, MUX_MULTB_ZERO, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_div_idle: got R=%0d D=%0d Z=%0d busy=%b expected idle",
                     bus.mux_R, bus.mux_D, bus.mux_Z, bus.busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_count != dc) begin
            errors++;
            $display("FAIL reset_mid_div_done: got %0d done pulses expected 0", done_count - dc);
        end
        e = sb_q.pop_back();
        run_op(F3_DIV, 32'd100, 32'd7, "after_reset");
    endtask

    task automatic test_kill();
        int   dc;
        exp_t e;
        dc = done_count;
        do_start(F3_MUL, 32'd6, 32'd7, "kill_mul");
        @(negedge clk);                       // MUL_WAIT
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_pre_busy: got %b expected 1", bus.busy);
        end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        checks++;
        if ({bus.mux_R, bus.mux_D, bus.mux_Z, bus.mux_multA, bus.mux_multB, bus.busy, bus.done} !==
            {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO, MUX_MULTB_ZERO, 2'b00}) begin
            errors++;
            $display("FAIL kill_idle: got R=%0d Z=%0d A=%0d B=%0d busy=%b expected idle",
                     bus.mux_R, bus.mux_Z, bus.mux_multA, bus.mux_multB, bus.busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_count != dc) begin
            errors++;
            $display("FAIL kill_done: got %0d done pulses expected 0", done_count - dc);
        end
        e = sb_q.pop_back();
        // kill and start together in IDLE: nothing is accepted.
        bus.funct3 = F3_DIV;
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        #1;
        checks++;
        if (bus.mux_R !== MUX_R_KEEP || bus.mux_Z !== MUX_Z_KEEP) begin
            errors++;
            $display("FAIL kill_start_selects: got R=%0d Z=%0d expected KEEP", bus.mux_R, bus.mux_Z);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_beats_start: got busy=%b expected 0", bus.busy);
        end
        run_op(F3_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "after_kill");
    endtask

    task automatic test_back_to_back();
        run_op(F3_MUL,    32'h1234_5678, 32'h9ABC_DEF0, "b2b_mul");
        run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, "b2b_mulh");
        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_mulhu");
        run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "b2b_div_ovf");
        run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, "b2b_rem_ovf");
        run_op(F3_DIV,    32'd100,       32'hFFFF_FFF9, "b2b_div_neg_divisor");
        run_op(F3_REM,    32'hFFFF_FF9C, 32'd7,         "b2b_rem_neg");
        run_op(F3_DIV,    32'hFFFF_FFFB, 32'd0,         "b2b_div_zero");
        run_op(F3_REM,    32'hFFFF_FFFB, 32'd0,         "b2b_rem_zero");
        run_op(F3_DIVU,   32'hFFFF_FFFF, 32'd3,         "b2b_divu");
        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, "b2b_rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = '0;
        bus.rs1_sign = 1'b0;
        bus.rs2_sign = 1'b0;
        bus.rs2_zero = 1'b0;
        bus.kill     = 1'b0;
        @(negedge clk);
        test_reset();
        test_mulh();
        test_div();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid_div();
        test_kill();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
